// File: rtl/rv32i_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control unit: FSM states, opcodes,
// select encodings and the per-opcode decode record.
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH_IDLE,
        FETCH,
        FETCH_WAIT,
        DECODE,
        EXECUTE,
        MEM_ACCESS,
        MEM_WAIT,
        WRITEBACK,
        TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_FUNCT = 2'd1,
        ALU_CMP   = 2'd2
    } alu_op_sel_t;

    typedef struct packed {
        logic        legal;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        alu_a_sel;
        logic        alu_b_sel;
        alu_op_sel_t alu_op;
        wb_sel_t     wb_sel;
        pc_sel_t     pc_sel;
    } op_info_t;

endpackage

// File: rtl/rv32i_opcode_decode.sv
// Combinational opcode classifier: legality, instruction class and the
// EXECUTE/WRITEBACK select fields each opcode uses.
module rv32i_opcode_decode
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_info_t   info
);

    always_comb begin
        info = '0;
        case (opcode)
            OPC_OP: begin
                info.legal  = 1'b1;
                info.alu_op = ALU_FUNCT;
            end
            OPC_OP_IMM: begin
                info.legal     = 1'b1;
                info.alu_b_sel = 1'b1;
                info.alu_op    = ALU_FUNCT;
            end
            OPC_LOAD: begin
                info.legal     = 1'b1;
                info.is_load   = 1'b1;
                info.alu_b_sel = 1'b1;
                info.wb_sel    = WB_MEM;
            end
            OPC_STORE: begin
                info.legal     = 1'b1;
                info.is_store  = 1'b1;
                info.alu_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                info.legal     = 1'b1;
                info.is_branch = 1'b1;
                info.alu_op    = ALU_CMP;
            end
            OPC_JAL: begin
                info.legal   = 1'b1;
                info.is_jump = 1'b1;
                info.wb_sel  = WB_PC4;
                info.pc_sel  = PC_IMM;
            end
            OPC_JALR: begin
                info.legal     = 1'b1;
                info.is_jump   = 1'b1;
                info.alu_b_sel = 1'b1;
                info.wb_sel    = WB_PC4;
                info.pc_sel    = PC_ALU;
            end
            OPC_AUIPC: begin
                info.legal     = 1'b1;
                info.alu_a_sel = 1'b1;
                info.alu_b_sel = 1'b1;
            end
            OPC_LUI: begin
                info.legal  = 1'b1;
                info.wb_sel = WB_IMM;
            end
            default: info = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_control.sv
// Main control FSM of the RV32I multi-cycle datapath: sequences each
// instruction and drives the datapath strobes and mux selects.
module rv32i_control
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        retire,
    output logic        illegal
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic [1:0] cnt;
    logic [6:0] opcode_q;
    logic [6:0] dec_opcode;
    op_info_t   info;
    logic       unused_instr_bits;

    // DECODE classifies the live IR; every later state uses the latched copy.
    assign dec_opcode        = (state == DECODE) ? instr[6:0] : opcode_q;
    assign unused_instr_bits = ^{instr[31:7], info.is_jump};

    rv32i_opcode_decode u_decode (
        .opcode (dec_opcode),
        .info   (info)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            cnt      <= '0;
            opcode_q <= '0;
            illegal  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FETCH || (state == MEM_ACCESS && info.is_load)) begin
                cnt <= CNT_INIT;
            end else if ((state == FETCH_WAIT || state == MEM_WAIT) && cnt != '0) begin
                cnt <= cnt - 2'd1;
            end
            if (state == DECODE) begin
                opcode_q <= instr[6:0];
                if (!info.legal) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    // run is a level: it is only looked at in FETCH_IDLE, so dropping it
    // lets the current instruction finish and parks at the boundary.
    always_comb begin
        next_state = state;
        case (state)
            FETCH_IDLE: if (run) next_state = FETCH;
            FETCH:      next_state = FETCH_WAIT;
            FETCH_WAIT: if (cnt == '0) next_state = DECODE;
            DECODE:     next_state = info.legal ? EXECUTE : TRAP;
            EXECUTE: begin
                if (info.is_branch) begin
                    next_state = FETCH_IDLE;
                end else if (info.is_load || info.is_store) begin
                    next_state = MEM_ACCESS;
                end else begin
                    next_state = WRITEBACK;
                end
            end
            MEM_ACCESS: next_state = info.is_load ? MEM_WAIT : FETCH_IDLE;
            MEM_WAIT:   if (cnt == '0) next_state = WRITEBACK;
            WRITEBACK:  next_state = FETCH_IDLE;
            TRAP:       next_state = TRAP;
            default:    next_state = FETCH_IDLE;
        endcase
    end

    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        alu_op_sel   = ALU_ADD;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        retire       = 1'b0;
        if (!reset) begin
            case (state)
                FETCH:      mem_re = 1'b1;
                FETCH_WAIT: ir_we = (cnt == '0);
                EXECUTE: begin
                    alu_a_sel  = info.alu_a_sel;
                    alu_b_sel  = info.alu_b_sel;
                    alu_op_sel = info.alu_op;
                    if (info.is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                        retire = 1'b1;
                    end
                end
                MEM_ACCESS: begin
                    mem_addr_sel = 1'b1;
                    if (info.is_load) begin
                        mem_re = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                WRITEBACK: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    wb_sel = info.wb_sel;
                    pc_sel = info.pc_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_control.sv
// Bench for rv32i_control: two instances (memory latency 1 and 3) checked
// cycle by cycle against a per-instruction expected output trace.
module tb_rv32i_control;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_a;
        logic       alu_b;
        logic [1:0] alu_op;
        logic       mem_re;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       retire;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run1 = 1'b0;
    logic        run3 = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] instr = '0;

    logic       pc_we1, ir_we1, rf_we1, alu_a_sel1, alu_b_sel1, mem_re1, mem_we1, mem_addr_sel1, retire1, illegal1;
    logic [1:0] pc_sel1, wb_sel1, alu_op_sel1;
    logic       pc_we3, ir_we3, rf_we3, alu_a_sel3, alu_b_sel3, mem_re3, mem_we3, mem_addr_sel3, retire3, illegal3;
    logic [1:0] pc_sel3, wb_sel3, alu_op_sel3;
    vec_t       obs1, obs3;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t exp_q[$];

    assign obs1 = {pc_we1, pc_sel1, ir_we1, rf_we1, wb_sel1, alu_a_sel1, alu_b_sel1,
                   alu_op_sel1, mem_re1, mem_we1, mem_addr_sel1, retire1};
    assign obs3 = {pc_we3, pc_sel3, ir_we3, rf_we3, wb_sel3, alu_a_sel3, alu_b_sel3,
                   alu_op_sel3, mem_re3, mem_we3, mem_addr_sel3, retire3};

    rv32i_control #(.MEM_LATENCY(1)) dut_lat1 (
        .clk(clk), .reset(reset), .run(run1), .instr(instr), .branch_taken(branch_taken),
        .pc_we(pc_we1), .pc_sel(pc_sel1), .ir_we(ir_we1), .rf_we(rf_we1), .wb_sel(wb_sel1),
        .alu_a_sel(alu_a_sel1), .alu_b_sel(alu_b_sel1), .alu_op_sel(alu_op_sel1),
        .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr_sel(mem_addr_sel1),
        .retire(retire1), .illegal(illegal1)
    );

    rv32i_control #(.MEM_LATENCY(3)) dut_lat3 (
        .clk(clk), .reset(reset), .run(run3), .instr(instr), .branch_taken(branch_taken),
        .pc_we(pc_we3), .pc_sel(pc_sel3), .ir_we(ir_we3), .rf_we(rf_we3), .wb_sel(wb_sel3),
        .alu_a_sel(alu_a_sel3), .alu_b_sel(alu_b_sel3), .alu_op_sel(alu_op_sel3),
        .mem_re(mem_re3), .mem_we(mem_we3), .mem_addr_sel(mem_addr_sel3),
        .retire(retire3), .illegal(illegal3)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: expected outputs per cycle for one instruction,
    // starting with the FETCH_IDLE cycle in which run is seen high.
    task automatic build_trace(input int lat, input logic [6:0] opc, input logic bt);
        vec_t v;
        logic legal;
        legal = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
        exp_q.push_back('0);
        v = '0; v.mem_re = 1'b1; exp_q.push_back(v);
        for (int i = 1; i < lat; i++) exp_q.push_back('0);
        v = '0; v.ir_we = 1'b1; exp_q.push_back(v);
        exp_q.push_back('0);
        if (!legal) return;
        v = '0;
        case (opc)
            OPC_OP:                        v.alu_op = 2'd1;
            OPC_OP_IMM:                    begin v.alu_b = 1'b1; v.alu_op = 2'd1; end
            OPC_LOAD, OPC_STORE, OPC_JALR: v.alu_b = 1'b1;
            OPC_AUIPC:                     begin v.alu_a = 1'b1; v.alu_b = 1'b1; end
            OPC_BRANCH: begin
                v.alu_op = 2'd2; v.pc_we = 1'b1; v.pc_sel = {1'b0, bt}; v.retire = 1'b1;
            end
            default: ;
        endcase
        exp_q.push_back(v);
        if (opc == OPC_BRANCH) return;
        if (opc == OPC_STORE) begin
            v = '0; v.mem_we = 1'b1; v.mem_addr_sel = 1'b1; v.pc_we = 1'b1; v.retire = 1'b1;
            exp_q.push_back(v);
            return;
        end
        if (opc == OPC_LOAD) begin
            v = '0; v.mem_re = 1'b1; v.mem_addr_sel = 1'b1; exp_q.push_back(v);
            for (int i = 0; i < lat; i++) exp_q.push_back('0);
        end
        v = '0; v.rf_we = 1'b1; v.pc_we = 1'b1; v.retire = 1'b1;
        case (opc)
            OPC_LOAD:           v.wb_sel = 2'd1;
            OPC_JAL, OPC_JALR:  v.wb_sel = 2'd2;
            OPC_LUI:            v.wb_sel = 2'd3;
            default:            v.wb_sel = 2'd0;
        endcase
        case (opc)
            OPC_JAL:  v.pc_sel = 2'd1;
            OPC_JALR: v.pc_sel = 2'd2;
            default:  v.pc_sel = 2'd0;
        endcase
        exp_q.push_back(v);
    endtask

    // driver: called at posedge+1 with the selected DUT in FETCH_IDLE
    task automatic run_instr(input int sel, input logic [31:0] ins, input logic bt, input int drop_at);
        vec_t e, ob;
        logic il;
        int   idx;
        instr = ins;
        branch_taken = bt;
        if (sel == 3) run3 = 1'b1; else run1 = 1'b1;
        build_trace(sel, ins[6:0], bt);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ob = (sel == 3) ? obs3 : obs1;
            il = (sel == 3) ? illegal3 : illegal1;
            n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL trace lat%0d instr=%h cycle %0d: got %h expected %h", sel, ins, idx, ob, e);
            end
            n_checks++;
            if ((ob.mem_re & ob.mem_we) !== 1'b0) begin
                n_fail++;
                $display("FAIL mem_re_we_exclusive lat%0d cycle %0d: got re=%b we=%b expected not both", sel, idx, ob.mem_re, ob.mem_we);
            end
            n_checks++;
            if (il !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_low lat%0d instr=%h cycle %0d: got %b expected 0", sel, ins, idx, il);
            end
            @(posedge clk);
            #1;
            idx++;
            if (idx == drop_at) begin
                if (sel == 3) run3 = 1'b0; else run1 = 1'b0;
            end
        end
        if (sel == 3) run3 = 1'b0; else run1 = 1'b0;
    endtask

    task automatic check_idle(input int sel, input int cycles, input string name);
        vec_t ob;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ob = (sel == 3) ? obs3 : obs1;
            n_checks++;
            if (ob !== '0) begin
                n_fail++;
                $display("FAIL %s lat%0d cycle %0d: got %h expected 0", name, sel, i, ob);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs1 !== '0 || obs3 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h expected 0/0", obs1, obs3);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (illegal1 !== 1'b0 || illegal3 !== 1'b0 || obs1 !== '0 || obs3 !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got ill=%b/%b out=%h/%h expected 0", illegal1, illegal3, obs1, obs3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_instr(1, 32'h00500093, 1'b0, -1);  // ADDI
        run_instr(1, 32'h0000A103, 1'b0, -1);  // LW
        run_instr(3, 32'h0000A103, 1'b0, -1);
        run_instr(1, 32'h00112023, 1'b0, -1);  // SW
        run_instr(3, 32'h00112023, 1'b0, -1);
        run_instr(1, 32'h00000063, 1'b1, -1);  // BEQ taken
        run_instr(1, 32'h00000063, 1'b0, -1);  // BEQ not taken
        run_instr(1, 32'h000080E7, 1'b0, -1);  // JALR
        run_instr(1, 32'h0000006F, 1'b0, -1);  // JAL
        run_instr(1, 32'h000000B7, 1'b0, -1);  // LUI
        run_instr(1, 32'h00000097, 1'b0, -1);  // AUIPC
        run_instr(3, 32'h002081B3, 1'b0, -1);  // ADD
    endtask

    task automatic test_back_to_back();
        run_instr(1, 32'h00500093, 1'b0, -1);
        run1 = 1'b1;
        run_instr(1, 32'h0000A103, 1'b0, -1);
        run_instr(3, 32'h00000063, 1'b1, -1);
        run_instr(3, 32'h000080E7, 1'b0, -1);
    endtask

    task automatic test_illegal();
        run_instr(1, 32'h0000007F, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (illegal1 !== 1'b1 || obs1 !== '0) begin
                n_fail++;
                $display("FAIL trap_hold cycle %0d: got ill=%b out=%h expected ill=1 out=0", i, illegal1, obs1);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (illegal1 !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_reset_clear: got %b expected 0", illegal1);
        end
        @(posedge clk);
        #1;
        run_instr(1, 32'h00500093, 1'b0, -1);
    endtask

    task automatic test_run_drop();
        run_instr(1, 32'h00500093, 1'b0, 4);
        check_idle(1, 10, "run_low_hold");
        run_instr(3, 32'h0000A103, 1'b0, 8);
        check_idle(3, 6, "run_low_hold");
        run_instr(1, 32'h00112023, 1'b0, -1);
    endtask

    task automatic test_reset_mid(input int cycles);
        instr = 32'h0000A103;
        run3 = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
        run3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs3 !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_strobes after %0d cycles: got %h expected 0", cycles, obs3);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle(3, 2, "reset_mid_idle");
        run_instr(3, 32'h0000A103, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [6:0]  opc_tab [9];
        logic [31:0] ins;
        int          sel;
        opc_tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                    OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
        for (int n = 0; n < 40; n++) begin
            sel = ($urandom_range(0, 1) == 1) ? 3 : 1;
            ins = $urandom();
            ins[6:0] = opc_tab[$urandom_range(0, 8)];
            run_instr(sel, ins, 1'($urandom_range(0, 1)), -1);
            check_idle(sel, $urandom_range(0, 2), "random_gap");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_run_drop();
        test_reset_mid(7);
        test_reset_mid(9);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
